// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_ctrl
// Description : 4x4 active-low keypad scanner with press/release debounce and
//               single-cycle decoded key strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int c_DW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
    localparam int c_BW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(SCAN_DIV - 1);
    localparam logic [c_BW-1:0] c_DEB_LAST   = c_BW'(DEBOUNCE_CNT - 1);
    localparam logic [c_DW-1:0] c_DWELL_ONE  = c_DW'(1);
    localparam logic [c_BW-1:0] c_DEB_ONE    = c_BW'(1);

    localparam logic [1:0] c_ST_SCAN     = 2'd0;
    localparam logic [1:0] c_ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_ST_PRESSED  = 2'd2;
    localparam logic [1:0] c_ST_RELEASE  = 2'd3;

    logic [1:0]      r_state,    w_state_nxt;
    logic [1:0]      r_col_idx,  w_col_idx_nxt;
    logic [3:0]      r_row_lat,  w_row_lat_nxt;
    logic [c_DW-1:0] r_dwell,    w_dwell_nxt;
    logic [c_BW-1:0] r_deb,      w_deb_nxt;
    logic [3:0]      r_key_code, w_key_code_nxt;
    logic            r_key_valid, w_key_valid_nxt;
    logic            r_key_held,  w_key_held_nxt;
    logic [3:0]      r_col;

    logic [3:0] w_row_n;
    logic       w_single_low;
    logic [1:0] w_row_idx;

    // A valid press has exactly one row pulled low; more than one is ghosting.
    assign w_row_n      = ~row;
    assign w_single_low = (w_row_n != 4'd0) && ((w_row_n & (w_row_n - 4'd1)) == 4'd0);

    always_comb begin
        w_row_idx = 2'd0;
        case (r_row_lat)
            4'b1101: w_row_idx = 2'd1;
            4'b1011: w_row_idx = 2'd2;
            4'b0111: w_row_idx = 2'd3;
            default: w_row_idx = 2'd0;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_col_idx_nxt   = r_col_idx;
        w_row_lat_nxt   = r_row_lat;
        w_dwell_nxt     = r_dwell;
        w_deb_nxt       = r_deb;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;
        case (r_state)
            c_ST_SCAN: begin
                if (r_dwell == c_DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (w_single_low) begin
                        w_row_lat_nxt = row;
                        w_deb_nxt     = '0;
                        w_state_nxt   = c_ST_DEBOUNCE;
                    end else begin
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + c_DWELL_ONE;
                end
            end
            c_ST_DEBOUNCE: begin
                if (row == r_row_lat) begin
                    if (r_deb == c_DEB_LAST) begin
                        w_state_nxt     = c_ST_PRESSED;
                        w_key_valid_nxt = 1'b1;
                        w_key_code_nxt  = {r_col_idx, w_row_idx};
                        w_key_held_nxt  = 1'b1;
                        w_deb_nxt       = '0;
                    end else begin
                        w_deb_nxt = r_deb + c_DEB_ONE;
                    end
                end else begin
                    w_state_nxt = c_ST_SCAN;
                    w_dwell_nxt = '0;
                    w_deb_nxt   = '0;
                end
            end
            c_ST_PRESSED: begin
                if (row == 4'b1111) begin
                    w_state_nxt = c_ST_RELEASE;
                    w_deb_nxt   = '0;
                end
            end
            default: begin
                if (row == 4'b1111) begin
                    if (r_deb == c_DEB_LAST) begin
                        w_state_nxt    = c_ST_SCAN;
                        w_key_held_nxt = 1'b0;
                        w_col_idx_nxt  = r_col_idx + 2'd1;
                        w_dwell_nxt    = '0;
                        w_deb_nxt      = '0;
                    end else begin
                        w_deb_nxt = r_deb + c_DEB_ONE;
                    end
                end else begin
                    w_deb_nxt = '0;
                end
            end
        endcase
    end

    // Column drive is decoded from the next index so it stays a clean register output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_SCAN;
            r_col_idx   <= 2'd0;
            r_row_lat   <= 4'b1111;
            r_dwell     <= '0;
            r_deb       <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_col       <= 4'b1110;
        end else begin
            r_state     <= w_state_nxt;
            r_col_idx   <= w_col_idx_nxt;
            r_row_lat   <= w_row_lat_nxt;
            r_dwell     <= w_dwell_nxt;
            r_deb       <= w_deb_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_held  <= w_key_held_nxt;
            r_col       <= ~(4'b0001 << w_col_idx_nxt);
        end
    end

    assign col       = r_col;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_ctrl
// Description : Directed self-checking bench for keypad_scan_ctrl
//               (SCAN_DIV=4, DEBOUNCE_CNT=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row = 4'b1111;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    int n_tests = 0;
    int n_fail  = 0;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge with reset released; the next edge is edge 1.
    task automatic do_reset();
        reset = 1'b1;
        row   = 4'b1111;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        row   = 4'b0111;
        tick();
        tick();
        n_tests++;
        if ({col, key_code, key_valid, key_held} !== {4'b1110, 4'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_vals: col=%b code=%h valid=%b held=%b, want 1110/0/0/0",
                     col, key_code, key_valid, key_held);
        end
        row = 4'b1111;
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_col;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            n_tests++;
            if (col !== exp_col || key_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_scan k=%0d: col=%b valid=%b, want col=%b valid=0",
                         k, col, key_valid, exp_col);
            end
        end
    endtask

    task automatic test_press_release();
        do_reset();
        repeat (4) tick();
        row = 4'b1011;
        repeat (4) tick();                 // edge 8: enter DEBOUNCE on col 1101
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_tests++;
            if (key_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL press_early k=%0d: valid=%b, want 0", k, key_valid);
            end
        end
        tick();
        n_tests++;
        if ({key_valid, key_code, key_held, col} !== {1'b1, 4'h6, 1'b1, 4'b1101}) begin
            n_fail++;
            $display("FAIL press_strobe: valid=%b code=%h held=%b col=%b, want 1/6/1/1101",
                     key_valid, key_code, key_held, col);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (key_valid !== 1'b0 || key_held !== 1'b1 || col !== 4'b1101) begin
                n_fail++;
                $display("FAIL press_hold k=%0d: valid=%b held=%b col=%b, want 0/1/1101",
                         k, key_valid, key_held, col);
            end
        end
        row = 4'b1111;
        tick();                            // enter RELEASE
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_tests++;
            if (key_held !== 1'b1) begin
                n_fail++;
                $display("FAIL release_early k=%0d: held=%b, want 1", k, key_held);
            end
        end
        tick();
        n_tests++;
        if (key_held !== 1'b0 || col !== 4'b1011 || key_code !== 4'h6) begin
            n_fail++;
            $display("FAIL release_done: held=%b col=%b code=%h, want 0/1011/6",
                     key_held, col, key_code);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        row = 4'b0111;
        repeat (4) tick();                 // edge 4: enter DEBOUNCE on col 1110
        repeat (2) tick();
        row = 4'b1111;
        tick();                            // edge 7: mismatch back to SCAN, dwell 0
        n_tests++;
        if (col !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0) begin
            n_fail++;
            $display("FAIL bounce_abort: col=%b valid=%b code=%h, want 1110/0/0",
                     col, key_valid, key_code);
        end
        repeat (3) tick();
        n_tests++;
        if (col !== 4'b1110) begin
            n_fail++;
            $display("FAIL bounce_dwell: col=%b, want 1110", col);
        end
        tick();
        n_tests++;
        if (col !== 4'b1101 || key_held !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_advance: col=%b held=%b, want 1101/0", col, key_held);
        end
    endtask

    task automatic test_ghost();
        do_reset();
        repeat (4) tick();
        row = 4'b1001;
        repeat (4) tick();                 // edge 8: ghost rejected
        n_tests++;
        if (col !== 4'b1011) begin
            n_fail++;
            $display("FAIL ghost_advance: col=%b, want 1011", col);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            n_tests++;
            if (key_valid !== 1'b0 || key_held !== 1'b0) begin
                n_fail++;
                $display("FAIL ghost_quiet k=%0d: valid=%b held=%b, want 0/0",
                         k, key_valid, key_held);
            end
        end
        row = 4'b1111;
    endtask

    task automatic test_key_f_no_repeat();
        int pulses;
        int pulse_at;
        do_reset();
        repeat (12) tick();
        row = 4'b0111;
        pulses   = 0;
        pulse_at = -1;
        for (int k = 13; k <= 112; k++) begin
            tick();
            if (key_valid === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = k;
            end
        end
        n_tests++;
        if (pulses !== 1 || pulse_at !== 24) begin
            n_fail++;
            $display("FAIL keyf_pulse: pulses=%0d at edge %0d, want 1 at edge 24", pulses, pulse_at);
        end
        n_tests++;
        if (key_code !== 4'hF || key_held !== 1'b1 || col !== 4'b0111) begin
            n_fail++;
            $display("FAIL keyf_state: code=%h held=%b col=%b, want F/1/0111", key_code, key_held, col);
        end
        row = 4'b1111;
        repeat (4) tick();
        row = 4'b0111;
        repeat (3) tick();
        row = 4'b1111;
        pulses = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (key_valid === 1'b1) pulses++;
            n_tests++;
            if (key_held !== 1'b1) begin
                n_fail++;
                $display("FAIL keyf_glitch k=%0d: held=%b, want 1", k, key_held);
            end
        end
        tick();
        if (key_valid === 1'b1) pulses++;
        n_tests++;
        if (key_held !== 1'b0 || col !== 4'b1110 || pulses !== 0 || key_code !== 4'hF) begin
            n_fail++;
            $display("FAIL keyf_release: held=%b col=%b pulses=%0d code=%h, want 0/1110/0/F",
                     key_held, col, pulses, key_code);
        end
    endtask

    task automatic test_reset_midway();
        // Mid-DEBOUNCE
        do_reset();
        row = 4'b0111;
        repeat (6) tick();
        reset = 1'b1;
        row   = 4'b1111;
        tick();
        n_tests++;
        if ({col, key_held, key_code, key_valid} !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_debounce: col=%b held=%b code=%h valid=%b, want 1110/0/0/0",
                     col, key_held, key_code, key_valid);
        end
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_tests++;
            if (key_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_debounce_quiet k=%0d: valid=%b, want 0", k, key_valid);
            end
        end
        // Mid-PRESSED
        do_reset();
        row = 4'b0111;
        repeat (12) tick();
        n_tests++;
        if (key_valid !== 1'b1 || key_code !== 4'h3 || key_held !== 1'b1) begin
            n_fail++;
            $display("FAIL key3_strobe: valid=%b code=%h held=%b, want 1/3/1",
                     key_valid, key_code, key_held);
        end
        repeat (2) tick();
        reset = 1'b1;
        row   = 4'b1111;
        tick();
        n_tests++;
        if ({col, key_held, key_code, key_valid} !== {4'b1110, 1'b0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_pressed: col=%b held=%b code=%h valid=%b, want 1110/0/0/0",
                     col, key_held, key_code, key_valid);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_press_release();
        test_bounce();
        test_ghost();
        test_key_f_no_repeat();
        test_reset_midway();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
